key_bank: RTL and testbench

Parametrised debounce and event bank for NUM_KEYS active-low push buttons, sitting between the board key pins and the DDS control logic (frequency step, amplitude, waveform select). Each key is synchronised and debounced independently, and produces press, release and auto-repeat pulses plus a debounced level. A built-in mode counter, advanced by one designated key, replaces the separate waveform-select flag logic.

---
 rtl/key_bank.sv | 143 ++++++++++++++
 tb/tb_key_bank.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/key_bank.sv
// Debounce and event bank for active-low push buttons: per-key synchroniser,
// debounce counter and press/hold/repeat FSM, plus a key-driven mode counter.

module key_bank_chan #(
    parameter int DEBOUNCE_CYC = 250,
    parameter int LONG_CYC     = 25000,
    parameter int REPEAT_CYC   = 5000,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);
    localparam int MAX_CYC = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int HW      = $clog2(MAX_CYC + 1);
    localparam int DW      = $clog2(DEBOUNCE_CYC);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} st_t;

    st_t           state;
    logic [1:0]    sync;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic          differ;
    logic          accept;

    // key_state doubles as the accepted debounced level (1 = pressed).
    assign differ = (~sync[1]) != key_state;
    assign accept = differ && (db_cnt == DW'(DEBOUNCE_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync        <= 2'b11;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            state       <= S_IDLE;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            sync        <= {sync[0], key_raw};
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;

            if (!differ || accept) db_cnt <= '0;
            else                   db_cnt <= db_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_HOLD;
                        key_state <= 1'b1;
                        key_press <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        state       <= S_IDLE;
                        key_state   <= 1'b0;
                        key_release <= 1'b1;
                        hold_cnt    <= '0;
                    end else if (REPEAT_EN && hold_cnt == HW'(LONG_CYC - 1)) begin
                        state      <= S_REPEAT;
                        key_repeat <= 1'b1;
                        hold_cnt   <= '0;
                    end else if (hold_cnt != HW'(LONG_CYC - 1)) begin
                        // saturates when repeat is disabled
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (accept) begin
                        state       <= S_IDLE;
                        key_state   <= 1'b0;
                        key_release <= 1'b1;
                        hold_cnt    <= '0;
                    end else if (hold_cnt == HW'(REPEAT_CYC - 1)) begin
                        key_repeat <= 1'b1;
                        hold_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

module key_bank #(
    parameter int NUM_KEYS     = 4,
    parameter int DEBOUNCE_CYC = 250,
    parameter int LONG_CYC     = 25000,
    parameter int REPEAT_CYC   = 5000,
    parameter bit REPEAT_EN    = 1'b1,
    parameter int MODE_KEY     = 0,
    parameter int MODE_COUNT   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_KEYS-1:0]           key_in,
    output logic [NUM_KEYS-1:0]           key_state,
    output logic [NUM_KEYS-1:0]           key_press,
    output logic [NUM_KEYS-1:0]           key_release,
    output logic [NUM_KEYS-1:0]           key_repeat,
    output logic [$clog2(MODE_COUNT)-1:0] mode_sel
);
    localparam int MW = $clog2(MODE_COUNT);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_bank_chan #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC    (LONG_CYC),
            .REPEAT_CYC  (REPEAT_CYC),
            .REPEAT_EN   (REPEAT_EN)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_raw    (key_in[g]),
            .key_state  (key_state[g]),
            .key_press  (key_press[g]),
            .key_release(key_release[g]),
            .key_repeat (key_repeat[g])
        );
    end

    // Advances only on the press pulse, so holding the key never steps the mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_sel <= '0;
        end else if (key_press[MODE_KEY]) begin
            if (mode_sel == MW'(MODE_COUNT - 1)) mode_sel <= '0;
            else                                mode_sel <= mode_sel + 1'b1;
        end
    end
endmodule

// File: tb/tb_key_bank.sv
// Directed bench for key_bank: expected pulse events (kind, cycle) are queued
// per key when stimulus is applied and matched against every observed pulse.

module tb_key_bank;
    localparam int NK = 4;
    localparam int D  = 200;
    localparam int L  = 1000;
    localparam int R  = 250;
    localparam int MC = 3;

    typedef struct {
        int kind;   // 0 press, 1 release, 2 repeat
        int t;
    } ev_t;

    logic          clk;
    logic          rst_n;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_state, key_press, key_release, key_repeat;
    logic [1:0]    mode_sel;
    logic [31:0]   outs;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    ev_t sb[NK][$];

    key_bank #(
        .NUM_KEYS(NK), .DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R),
        .REPEAT_EN(1'b1), .MODE_KEY(0), .MODE_COUNT(MC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in),
        .key_state(key_state), .key_press(key_press), .key_release(key_release),
        .key_repeat(key_repeat), .mode_sel(mode_sel)
    );

    assign outs = {14'b0, key_state, key_press, key_release, key_repeat, mode_sel};

    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_ev(input int k, input int kind, input int t);
        ev_t e;
        e.kind = kind;
        e.t    = t;
        sb[k].push_back(e);
    endfunction

    // Key k driven low now and high again n cycles later.
    function automatic void sched_hold(input int k, input int n);
        int p, rel;
        p   = cyc + D + 2;
        rel = cyc + n + D + 2;
        push_ev(k, 0, p);
        for (int t = p + L; t < rel; t += R) push_ev(k, 2, t);
        push_ev(k, 1, rel);
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Every pulse seen must be the next queued event for that key.
    always @(negedge clk) begin : monitor
        logic [2:0] p;
        ev_t e;
        for (int k = 0; k < NK; k++) begin
            p = {key_repeat[k], key_release[k], key_press[k]};
            for (int j = 0; j < 3; j++) begin
                if (p[j] === 1'b1) begin
                    checks++;
                    if (sb[k].size() == 0) begin
                        e.kind = -1;
                        e.t    = -1;
                    end else begin
                        e = sb[k].pop_front();
                    end
                    assert (e.kind == j && e.t == cyc) else begin
                        failures++;
                        $error("FAIL ev_key%0d: got kind=%0d cyc=%0d, want kind=%0d cyc=%0d",
                               k, j, cyc, e.kind, e.t);
                    end
                end
            end
        end
    end

    initial begin : stim
        int n0, n1, exp_mode;
        rst_n  = 1'b0;
        key_in = '1;
        repeat (3) @(negedge clk);
        chk("rst_outs", outs, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            chk("idle_outs", outs, 32'h0);
        end

        // Clean press/release on key 2
        n0 = cyc; key_in[2] = 1'b0; sched_hold(2, 300);
        wait_until(n0 + D + 1); chk("k2_state_pre", 32'(key_state[2]), 32'd0);
        @(negedge clk);         chk("k2_state_on", 32'(key_state[2]), 32'd1);
        wait_until(n0 + 300); key_in[2] = 1'b1;
        wait_until(n0 + 300 + D + 1); chk("k2_state_hold", 32'(key_state[2]), 32'd1);
        @(negedge clk);               chk("k2_state_off", 32'(key_state[2]), 32'd0);
        repeat (20) @(negedge clk);

        // Bouncing key 1: ten 50-cycle segments, then stable low
        for (int i = 0; i < 10; i++) begin
            key_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (50) @(negedge clk);
        end
        chk("k1_bounce_state", 32'(key_state[1]), 32'd0);
        n0 = cyc; key_in[1] = 1'b0; sched_hold(1, 300);
        wait_until(n0 + 300); key_in[1] = 1'b1;
        wait_until(n0 + 300 + D + 12);

        // Long hold on key 3 with auto-repeat, then quiet after release
        n0 = cyc; key_in[3] = 1'b0; sched_hold(3, 2000);
        wait_until(n0 + 2000); key_in[3] = 1'b1;
        wait_until(n0 + 2000 + D + 300);
        chk("k3_state_off", 32'(key_state[3]), 32'd0);

        // Mode key presses: 1,2,0,1
        exp_mode = 0;
        for (int i = 0; i < 4; i++) begin
            n0 = cyc; key_in[0] = 1'b0; sched_hold(0, 300);
            wait_until(n0 + D + 2); chk("mode_at_press", 32'(mode_sel), 32'(exp_mode));
            exp_mode = (exp_mode + 1) % MC;
            @(negedge clk);         chk("mode_after_press", 32'(mode_sel), 32'(exp_mode));
            wait_until(n0 + 300); key_in[0] = 1'b1;
            wait_until(n0 + 300 + D + 12);
        end
        chk("mode_seq_end", 32'(mode_sel), 32'd1);

        // Non-mode key leaves mode alone
        n0 = cyc; key_in[3] = 1'b0; sched_hold(3, 300);
        wait_until(n0 + 300); key_in[3] = 1'b1;
        wait_until(n0 + 300 + D + 12);
        chk("mode_k3", 32'(mode_sel), 32'd1);

        // Long hold on mode key: one step for the press, none for repeats
        n0 = cyc; key_in[0] = 1'b0; sched_hold(0, 1500);
        wait_until(n0 + D + 3); chk("mode_long_press", 32'(mode_sel), 32'd2);
        wait_until(n0 + 1460);  chk("mode_long_rpt", 32'(mode_sel), 32'd2);
        wait_until(n0 + 1500); key_in[0] = 1'b1;
        wait_until(n0 + 1500 + D + 12);
        chk("mode_long_end", 32'(mode_sel), 32'd2);

        // Simultaneous presses on keys 1 and 2, then reset mid-hold
        n0 = cyc; key_in[2:1] = 2'b00;
        push_ev(1, 0, n0 + D + 2);
        push_ev(2, 0, n0 + D + 2);
        wait_until(n0 + D + 2); chk("k12_state", 32'(key_state), 32'h6);
        @(negedge clk);         chk("mode_k12", 32'(mode_sel), 32'd2);
        wait_until(n0 + 400); rst_n = 1'b0;
        @(negedge clk);             chk("rst_mid_outs", outs, 32'h0);
        repeat (3) @(negedge clk);  chk("rst_mid_hold", outs, 32'h0);

        // Keys still held across reset release: fresh press after debounce
        rst_n = 1'b1; n1 = cyc;
        sched_hold(1, 300);
        sched_hold(2, 300);
        wait_until(n1 + D + 1); chk("k12_pre_fresh", 32'(key_state), 32'h0);
        @(negedge clk);         chk("k12_fresh", 32'(key_state), 32'h6);
        wait_until(n1 + 300); key_in[2:1] = 2'b11;
        wait_until(n1 + 300 + D + 20);
        chk("final_mode", 32'(mode_sel), 32'd0);

        for (int k = 0; k < NK; k++) chk($sformatf("sb_empty_k%0d", k), 32'(sb[k].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
